// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (I) and data (D) requesters, one transaction at a time.
// D has fixed priority; a streak limit lets a pending fetch through after MAX_D_STREAK data grants.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_req_valid,
    output logic                i_req_ready,
    input  logic [ADDR_W-1:0]   i_req_addr,
    output logic                i_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [DATA_W-1:0]   i_rsp_data,
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic                d_req_we,
    input  logic [DATA_W/8-1:0] d_req_wstrb,
    input  logic [DATA_W-1:0]   d_req_wdata,
    output logic                d_rsp_valid,
    input  logic                d_rsp_ready,
    output logic [DATA_W-1:0]   d_rsp_data,
    output logic                m_req_valid,
    input  logic                m_req_ready,
    output logic [ADDR_W-1:0]   m_req_addr,
    output logic                m_req_we,
    output logic [DATA_W/8-1:0] m_req_wstrb,
    output logic [DATA_W-1:0]   m_req_wdata,
    input  logic                m_rsp_valid,
    output logic                m_rsp_ready,
    input  logic [DATA_W-1:0]   m_rsp_data,
    output logic                owner,
    output logic                busy
);
    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
    state_t     state, state_nx;
    logic [7:0] streak;
    logic       d_win, i_win, active;
    assign active = !reset;
    always_comb begin
        d_win       = active && state == IDLE && d_req_valid && !(i_req_valid && streak == 8'(MAX_D_STREAK));
        i_win       = active && state == IDLE && i_req_valid && !d_win;
        d_req_ready = d_win;
        i_req_ready = i_win;
        m_req_valid = active && state == REQ;
        m_rsp_ready = active && state == RSP && (owner ? d_rsp_ready : i_rsp_ready);
        i_rsp_valid = active && state == RSP && !owner && m_rsp_valid;
        d_rsp_valid = active && state == RSP && owner && m_rsp_valid;
        i_rsp_data  = m_rsp_data;
        d_rsp_data  = m_rsp_data;
        busy        = active && state != IDLE;
        state_nx    = (d_win || i_win) ? REQ :
                      (m_req_valid && m_req_ready) ? RSP :
                      (state == RSP && m_rsp_valid && m_rsp_ready) ? IDLE : state;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            streak      <= 8'd0;
            owner       <= 1'b0;
            m_req_addr  <= '0;
            m_req_we    <= 1'b0;
            m_req_wstrb <= '0;
            m_req_wdata <= '0;
        end else begin
            state <= state_nx;
            if (d_win) begin
                m_req_addr  <= d_req_addr;
                m_req_we    <= d_req_we;
                m_req_wstrb <= d_req_wstrb;
                m_req_wdata <= d_req_wdata;
                owner       <= 1'b1;
                // streak only grows while a fetch is actually being held off
                streak      <= !i_req_valid ? 8'd0 :
                               (streak < 8'(MAX_D_STREAK)) ? streak + 8'd1 : streak;
            end else if (i_win) begin
                m_req_addr  <= i_req_addr;
                m_req_we    <= 1'b0;
                m_req_wstrb <= '0;
                m_req_wdata <= '0;
                owner       <= 1'b0;
                streak      <= 8'd0;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: transaction-level model checked every cycle, plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;
    localparam int MAXS = 4;
    logic        clock = 0, reset = 1;
    logic        i_req_valid = 0, i_req_ready, i_rsp_valid, i_rsp_ready = 1;
    logic [31:0] i_req_addr = 0, i_rsp_data;
    logic        d_req_valid = 0, d_req_ready, d_req_we = 0, d_rsp_valid, d_rsp_ready = 1;
    logic [31:0] d_req_addr = 0, d_req_wdata = 0, d_rsp_data;
    logic [3:0]  d_req_wstrb = 0;
    logic        m_req_valid, m_req_ready = 0, m_req_we, m_rsp_valid = 0, m_rsp_ready;
    logic [31:0] m_req_addr, m_req_wdata, m_rsp_data = 0;
    logic [3:0]  m_req_wstrb;
    logic        owner, busy;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(MAXS)) dut (
        .clock(clock), .reset(reset),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready), .i_rsp_data(i_rsp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_we(d_req_we), .d_req_wstrb(d_req_wstrb), .d_req_wdata(d_req_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
        .m_req_we(m_req_we), .m_req_wstrb(m_req_wstrb), .m_req_wdata(m_req_wdata),
        .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready), .m_rsp_data(m_rsp_data),
        .owner(owner), .busy(busy)
    );

    always #5 clock = ~clock;

    int total = 0, bad = 0;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: one open transaction record plus the fairness count
    bit          chk_en = 0;
    bit          mdl_open = 0, mdl_issued = 0, mdl_who = 0, mdl_owner = 0, mdl_we = 0;
    logic [31:0] mdl_addr = 0, mdl_wdata = 0;
    logic [3:0]  mdl_wstrb = 0;
    int          mdl_streak = 0;
    bit          e_dw, e_iw, e_mq, e_mr, e_iv, e_dv, rs;
    int          glog[$];
    int          icnt = 0, dcnt = 0, reqv_cycles = 0;
    bit          g_i = 0, g_d = 0, req_fire_s = 0, rsp_fire_s = 0, rst_s = 0;

    always @(negedge clock) begin
        req_fire_s = m_req_valid && m_req_ready;
        rsp_fire_s = m_rsp_valid && m_rsp_ready;
        rst_s      = reset;
        if (i_req_ready) begin glog.push_back(0); g_i = 1; end
        if (d_req_ready) begin glog.push_back(1); g_d = 1; end
        if (i_rsp_valid && i_rsp_ready) icnt++;
        if (d_rsp_valid && d_rsp_ready) dcnt++;
        if (m_req_valid) reqv_cycles++;
        if (chk_en) begin
            rs   = reset;
            e_dw = !rs && !mdl_open && d_req_valid && !(i_req_valid && mdl_streak == MAXS);
            e_iw = !rs && !mdl_open && i_req_valid && !e_dw;
            e_mq = !rs && mdl_open && !mdl_issued;
            e_mr = !rs && mdl_open && mdl_issued && (mdl_who ? d_rsp_ready : i_rsp_ready);
            e_iv = !rs && mdl_open && mdl_issued && !mdl_who && m_rsp_valid;
            e_dv = !rs && mdl_open && mdl_issued && mdl_who && m_rsp_valid;
            check("i_req_ready", i_req_ready, e_iw);
            check("d_req_ready", d_req_ready, e_dw);
            check("m_req_valid", m_req_valid, e_mq);
            check("m_rsp_ready", m_rsp_ready, e_mr);
            check("i_rsp_valid", i_rsp_valid, e_iv);
            check("d_rsp_valid", d_rsp_valid, e_dv);
            check("busy", busy, !rs && mdl_open);
            check("owner", owner, mdl_owner);
            check("m_req_addr", m_req_addr, mdl_addr);
            check("m_req_we", m_req_we, mdl_we);
            check("m_req_wstrb", m_req_wstrb, mdl_wstrb);
            check("m_req_wdata", m_req_wdata, mdl_wdata);
            if (e_iv) check("i_rsp_data", i_rsp_data, m_rsp_data);
            if (e_dv) check("d_rsp_data", d_rsp_data, m_rsp_data);
            if (rs) begin
                {mdl_open, mdl_issued, mdl_who, mdl_owner, mdl_we} = '0;
                mdl_addr = 0; mdl_wdata = 0; mdl_wstrb = 0; mdl_streak = 0;
            end else if (e_dw || e_iw) begin
                mdl_open = 1; mdl_issued = 0; mdl_who = e_dw; mdl_owner = e_dw;
                mdl_addr  = e_dw ? d_req_addr : i_req_addr;
                mdl_we    = e_dw && d_req_we;
                mdl_wstrb = e_dw ? d_req_wstrb : 4'h0;
                mdl_wdata = e_dw ? d_req_wdata : 32'h0;
                mdl_streak = (e_iw || !i_req_valid) ? 0 : (mdl_streak + 1 > MAXS ? MAXS : mdl_streak + 1);
            end else if (e_mq && m_req_ready) mdl_issued = 1;
            else if (e_mr && m_rsp_valid) mdl_open = 0;
        end
    end

    // memory slave: optional request stall, then one response carrying mem_data
    int          req_stall = 0, stall = 0;
    bit          mphase = 0;
    logic [31:0] mem_data = 0;
    always @(posedge clock) begin
        #1;
        if (rst_s) begin
            mphase = 0; stall = 0; m_req_ready = 0;
        end else if (!mphase) begin
            m_rsp_valid = 0;
            if (req_fire_s) begin
                mphase = 1; stall = 0; m_req_ready = 0; m_rsp_valid = 1; m_rsp_data = mem_data;
            end else if (m_req_valid) begin
                if (stall >= req_stall) m_req_ready = 1; else stall++;
            end
        end else if (rsp_fire_s) begin
            mphase = 0; m_rsp_valid = 0;
        end
    end

    bit i_one = 1, d_one = 1;
    task automatic tick();
        @(posedge clock); #1;
        if (i_one && g_i) i_req_valid = 0;
        if (d_one && g_d) d_req_valid = 0;
        g_i = 0; g_d = 0;
    endtask

    task automatic settle();
        int t = 0;
        while (t < 200 && (busy || i_req_valid || d_req_valid)) begin tick(); t++; end
        if (t == 200) begin total++; bad++; $display("FAIL settle_timeout busy=%0b required=0", busy); end
        tick();
    endtask

    task automatic wait_grants(input int n);
        int t = 0;
        while (t < 300 && glog.size() < n) begin tick(); t++; end
        if (t == 300) begin total++; bad++; $display("FAIL grant_timeout got=%0d required=%0d", glog.size(), n); end
    endtask

    int exp_seq[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int c0, r0, seen, t;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clock);
        #1 chk_en = 1;
        tick();
        reset = 0;
        @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 0);
        check("rst_m_req_valid", m_req_valid, 0);
        check("rst_m_req_addr", m_req_addr, 0);
        check("rst_m_rsp_ready", m_rsp_ready, 0);
        tick();

        // single fetch
        mem_data = 32'h13; i_req_addr = 32'h200; i_req_valid = 1;
        @(negedge clock); check("fetch_grant", i_req_ready, 1);
        tick();
        @(negedge clock); check("fetch_mreq_v", m_req_valid, 1);
        check("fetch_addr", m_req_addr, 32'h200); check("fetch_we", m_req_we, 0);
        tick();
        @(negedge clock); check("fetch_rsp_v", i_rsp_valid, 1); check("fetch_data", i_rsp_data, 32'h13);
        tick();
        @(negedge clock); check("fetch_idle", busy, 0);
        settle();

        // store
        mem_data = 32'h0; d_req_addr = 32'h1000; d_req_we = 1; d_req_wstrb = 4'hF; d_req_wdata = 32'hAAAAAAAA;
        d_req_valid = 1;
        @(negedge clock); check("store_grant", d_req_ready, 1);
        tick();
        @(negedge clock); check("store_addr", m_req_addr, 32'h1000); check("store_we", m_req_we, 1);
        check("store_wstrb", m_req_wstrb, 4'hF); check("store_wdata", m_req_wdata, 32'hAAAAAAAA);
        check("store_owner", owner, 1);
        tick();
        @(negedge clock); check("store_ack", d_rsp_valid, 1); check("store_no_i", i_rsp_valid, 0);
        tick();
        @(negedge clock); check("store_ack_pulse", d_rsp_valid, 0);
        settle();

        // contention
        glog.delete(); d_req_we = 0; d_req_addr = 32'h2000; i_req_addr = 32'h204;
        i_req_valid = 1; d_req_valid = 1;
        wait_grants(2); settle();
        check("cont_first", glog[0], 1); check("cont_second", glog[1], 0);

        // starvation guard
        reset = 1; tick(); reset = 0; tick();
        glog.delete(); i_one = 0; d_one = 0; i_req_valid = 1; d_req_valid = 1;
        wait_grants(10);
        i_req_valid = 0; d_req_valid = 0; i_one = 1; d_one = 1;
        settle();
        for (int k = 0; k < 10; k++) check($sformatf("streak_grant%0d", k), glog[k], exp_seq[k]);

        // backpressure
        req_stall = 5; i_rsp_ready = 0; mem_data = 32'h55AA; c0 = icnt; r0 = reqv_cycles;
        i_req_addr = 32'h300; i_req_valid = 1;
        tick(); i_req_addr = 32'hDEAD0000; d_req_addr = 32'hBEEF0000;
        seen = 0; t = 0;
        while (seen < 3 && t < 50) begin
            @(negedge clock);
            if (m_rsp_valid && busy) begin seen++; check("bp_mrsp_ready", m_rsp_ready, 0); end
            tick(); t++;
        end
        i_rsp_ready = 1;
        settle();
        check("bp_one_rsp", icnt - c0, 1);
        check("bp_req_cycles", reqv_cycles - r0, 6);
        req_stall = 0;

        // reset during response phase
        d_rsp_ready = 0; d_req_we = 1; d_req_addr = 32'h40; d_req_valid = 1; c0 = dcnt;
        seen = 0; t = 0;
        while (!seen && t < 50) begin
            @(negedge clock); seen = m_rsp_valid && busy;
            tick(); t++;
        end
        check("rst_reached_rsp", seen, 1);
        reset = 1; d_rsp_ready = 1;
        tick(); reset = 0;
        @(negedge clock);
        check("rstrsp_busy", busy, 0); check("rstrsp_owner", owner, 0);
        check("rstrsp_addr", m_req_addr, 0); check("rstrsp_we", m_req_we, 0);
        check("rstrsp_mrr", m_rsp_ready, 0); check("rstrsp_dv", d_rsp_valid, 0);
        settle();
        check("rstrsp_no_fwd", dcnt - c0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one 32-bit memory port between the core's instruction-fetch requester (I) and its data requester (D).
- Sits between the core fetch/load-store logic and the single memory slave.
- Allows exactly one outstanding transaction at a time.
- D has fixed priority over I. A streak limit guarantees fetch progress under sustained data traffic.

Parameters:
- ADDR_W, 32, address width of all request channels.
- DATA_W, 32, data width; byte-strobe width is DATA_W/8.
- MAX_D_STREAK, 4, max consecutive D grants while I is pending; range 1..255.

Ports:
- clock  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- i_req_valid  in  1  fetch request valid.
- i_req_ready  out  1  fetch request accepted this cycle.
- i_req_addr  in  ADDR_W  fetch address.
- i_rsp_valid  out  1  fetch response valid.
- i_rsp_ready  in  1  fetch requester accepts response.
- i_rsp_data  out  DATA_W  fetched word.
- d_req_valid  in  1  data request valid.
- d_req_ready  out  1  data request accepted this cycle.
- d_req_addr  in  ADDR_W  data address.
- d_req_we  in  1  1=store, 0=load.
- d_req_wstrb  in  DATA_W/8  store byte enables.
- d_req_wdata  in  DATA_W  store data.
- d_rsp_valid  out  1  data response valid (load data or store ack).
- d_rsp_ready  in  1  data requester accepts response.
- d_rsp_data  out  DATA_W  load data; don't-care on store ack.
- m_req_valid  out  1  request to memory valid.
- m_req_ready  in  1  memory accepts request.
- m_req_addr  out  ADDR_W  held address.
- m_req_we  out  1  held write enable.
- m_req_wstrb  out  DATA_W/8  held strobes.
- m_req_wdata  out  DATA_W  held write data.
- m_rsp_valid  in  1  memory response valid; one response per request, including writes.
- m_rsp_ready  out  1  arbiter accepts memory response.
- m_rsp_data  in  DATA_W  memory read data.
- owner  out  1  current/last grant: 0=I, 1=D.
- busy  out  1  high in REQ or RSP.

Behaviour:
- Reset values:
  - State machine: IDLE.
  - All valid/ready outputs: 0.
  - Held fields: 0.
  - owner=0, busy=0, streak counter=0.
  - Reset mid-transaction abandons it. Any late m_rsp_valid arriving in IDLE is not accepted (m_rsp_ready=0).
- State IDLE: select a winner combinationally.
  - If d_req_valid and !(i_req_valid and streak==MAX_D_STREAK), D wins.
  - Else if i_req_valid, I wins.
  - Winner's req_ready=1 for one cycle. The loser's req_ready=0.
  - On that edge, latch the winner's fields into hold registers; set owner; go to REQ.
  - For I: held we=0, wstrb=0, wdata=0.
  - Neither valid: stay in IDLE, all readies 0.
- Streak counter updates on each grant:
  - D grant while i_req_valid=1: streak+1, saturating at MAX_D_STREAK.
  - D grant while i_req_valid=0: streak=0.
  - I grant: streak=0.
- State REQ: m_req_valid=1 with held fields, which stay stable until m_req_ready. On m_req_valid & m_req_ready, go to RSP. Both upstream req_ready=0.
- State RSP: route memory response to the owner.
  - Owner's rsp_valid = m_rsp_valid; owner's rsp_data = m_rsp_data.
  - m_rsp_ready = owner's rsp_ready. The non-owner's rsp_valid=0.
  - On m_rsp_valid & m_rsp_ready, go to IDLE.
- Latency:
  - Request accepted at edge N; m_req_valid at cycle N+1.
  - Response is combinational pass-through, zero added latency.
  - Minimum issue-to-issue spacing is 3 cycles: IDLE, REQ, RSP each ≥1 cycle.
- No new request is accepted while busy. Back-to-back requests simply wait.
- Simultaneous I and D valid in IDLE are resolved by the priority rule above. A requester dropping valid before being granted is legal and loses nothing.
- busy=1 exactly when the state is REQ or RSP.

Test Plan:
- Single fetch: i_req_valid, addr=0x200, m_req_ready=1, m_rsp 1 cycle later with data=0x13 → m_req_addr=0x200, we=0; i_rsp_data=0x13; state back in IDLE after 3 cycles.
- Store: d addr=0x1000, we=1, wstrb=0xF, wdata=0xAAAAAAAA → m_req fields match exactly; d_rsp_valid pulses on ack; i_rsp_valid stays 0.
- Contention: I and D valid together in IDLE → D granted first, then I on the next IDLE; owner sequence 1,0.
- Starvation guard, MAX_D_STREAK=4: I and D both valid continuously → grants D,D,D,D,I,D,D,D,D,I…
- Backpressure: m_req_ready low 5 cycles, then i_rsp_ready low 3 cycles with m_rsp_valid high → m_req fields stable throughout; m_rsp_ready mirrors i_rsp_ready; exactly one response delivered.
- Reset in RSP with m_rsp_valid high → next cycle: IDLE, busy=0, all outputs at reset values, no response forwarded.
